// File: rtl/fhe_controller.sv
// fhe_controller
//
// Sequencing controller for the encrypted-arithmetic datapath. It accepts one
// descriptor, which is an opcode plus three base addresses. It then walks every
// row of an LWE ciphertext: rows 0..DIMENSION-1 are the a[i] elements and row
// DIMENSION is the b term. For each row it presents operand and result
// addresses to the compute unit and scratch memory.
//
// Ports
//   clk            : rising-edge clock
//   rst_n          : asynchronous reset, ACTIVE HIGH despite the name
//   opcode         : operation to latch (0 ENC, 1 DEC, 2 ADD, 3 MUL)
//   config_en      : load descriptor (only honoured in IDLE)
//   op1_base_addr  : operand-1 base address
//   op2_base_addr  : operand-2 base address
//   out_base_addr  : result base address
//   opcode_out     : latched opcode, held until the next accepted descriptor
//   op1_addr       : operand-1 base + row (wraps modulo 2^ADDR_WIDTH)
//   op2_addr       : operand-2 base + row
//   out_addr       : result base + row
//   op_select      : 0 = a-vector path, 1 = b-term path (row == DIMENSION)
//   en             : datapath enable for the current row
//   done           : one-cycle completion pulse
//   row            : current row index
//
// All outputs come straight from flops. The addresses are precomputed one
// cycle ahead, so they never glitch relative to clk.

module fhe_controller #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 21,
  parameter int DIMENSION          = 3,
  parameter int DIM_WIDTH          = 2,
  parameter int BIG_N              = 30,
  parameter int PARALLEL           = 1,
  parameter int ADDR_WIDTH         = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            opcode,
  input  logic                  config_en,
  input  logic [ADDR_WIDTH-1:0] op1_base_addr,
  input  logic [ADDR_WIDTH-1:0] op2_base_addr,
  input  logic [ADDR_WIDTH-1:0] out_base_addr,
  output logic [1:0]            opcode_out,
  output logic [ADDR_WIDTH-1:0] op1_addr,
  output logic [ADDR_WIDTH-1:0] op2_addr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  op_select,
  output logic                  en,
  output logic                  done,
  output logic [DIM_WIDTH:0]    row
);

  // Only one row per beat is implemented. row must be able to hold DIMENSION.
  // The system constants must be sane, even though they do not affect
  // sequencing.
  localparam bit CFG_OK = (PARALLEL == 1) && (DIMENSION >= 1) &&
                          ((DIMENSION - 1) < (2 ** DIM_WIDTH)) &&
                          (PLAINTEXT_MODULUS > 0) && (PLAINTEXT_WIDTH > 0) &&
                          (CIPHERTEXT_MODULUS > 0) && (CIPHERTEXT_WIDTH > 0) &&
                          (BIG_N > 0) && (ADDR_WIDTH > 0);

  if (!CFG_OK) begin : g_cfg_check
    $error("fhe_controller: unsupported parameter set");
  end

  localparam logic [DIM_WIDTH:0] LAST_ROW = (DIM_WIDTH + 1)'(DIMENSION);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [DIM_WIDTH:0]    row_q;
  logic [DIM_WIDTH:0]    row_d;
  logic [ADDR_WIDTH-1:0] row_ext_d;
  logic [1:0]            opcode_q;
  logic [ADDR_WIDTH-1:0] op1_base_q;
  logic [ADDR_WIDTH-1:0] op2_base_q;
  logic [ADDR_WIDTH-1:0] out_base_q;
  logic [ADDR_WIDTH-1:0] op1_addr_q;
  logic [ADDR_WIDTH-1:0] op2_addr_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic                  op_select_q;
  logic                  en_q;
  logic                  done_q;

  // Compute the next row index and zero-extend or truncate it to the address
  // width, ready for base + row.
  always_comb begin
    row_d     = row_q + {{DIM_WIDTH{1'b0}}, 1'b1};
    row_ext_d = ADDR_WIDTH'(row_d);
  end

  // Controller FSM. Outputs are registered, and each address is set up one
  // cycle ahead, for the row the FSM is about to present.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      opcode_q    <= 2'd0;
      op1_base_q  <= '0;
      op2_base_q  <= '0;
      out_base_q  <= '0;
      op1_addr_q  <= '0;
      op2_addr_q  <= '0;
      out_addr_q  <= '0;
      op_select_q <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q      <= 1'b0;
          row_q       <= '0;
          op_select_q <= 1'b0;
          if (config_en) begin
            // Row 0 is presented on the cycle right after the descriptor is
            // accepted, so the addresses are the raw input bases.
            state_q    <= ST_RUN;
            opcode_q   <= opcode;
            op1_base_q <= op1_base_addr;
            op2_base_q <= op2_base_addr;
            out_base_q <= out_base_addr;
            op1_addr_q <= op1_base_addr;
            op2_addr_q <= op2_base_addr;
            out_addr_q <= out_base_addr;
            en_q       <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
            op1_addr_q <= op1_base_q;
            op2_addr_q <= op2_base_q;
            out_addr_q <= out_base_q;
            en_q       <= 1'b0;
          end
        end

        ST_RUN: begin
          if (row_q != LAST_ROW) begin
            state_q     <= ST_RUN;
            row_q       <= row_d;
            op1_addr_q  <= op1_base_q + row_ext_d;
            op2_addr_q  <= op2_base_q + row_ext_d;
            out_addr_q  <= out_base_q + row_ext_d;
            op_select_q <= (row_d == LAST_ROW);
            en_q        <= 1'b1;
            done_q      <= 1'b0;
          end else begin
            state_q     <= ST_DONE;
            row_q       <= '0;
            op1_addr_q  <= op1_base_q;
            op2_addr_q  <= op2_base_q;
            out_addr_q  <= out_base_q;
            op_select_q <= 1'b0;
            en_q        <= 1'b0;
            done_q      <= 1'b1;
          end
        end

        ST_DONE: begin
          // config_en is deliberately not sampled here. A new descriptor is
          // taken only from the first IDLE cycle.
          state_q     <= ST_IDLE;
          row_q       <= '0;
          op1_addr_q  <= op1_base_q;
          op2_addr_q  <= op2_base_q;
          out_addr_q  <= out_base_q;
          op_select_q <= 1'b0;
          en_q        <= 1'b0;
          done_q      <= 1'b0;
        end

        default: begin
          state_q     <= ST_IDLE;
          row_q       <= '0;
          op1_addr_q  <= op1_base_q;
          op2_addr_q  <= op2_base_q;
          out_addr_q  <= out_base_q;
          op_select_q <= 1'b0;
          en_q        <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign opcode_out = opcode_q;
  assign op1_addr   = op1_addr_q;
  assign op2_addr   = op2_addr_q;
  assign out_addr   = out_addr_q;
  assign op_select  = op_select_q;
  assign en         = en_q;
  assign done       = done_q;
  assign row        = row_q;

endmodule

// File: tb/tb_fhe_controller.sv
// Self-checking bench for fhe_controller. A behavioural model tracks the
// occupancy slot of the current descriptor: -1 for idle, 0..DIMENSION for the
// rows and DIMENSION+1 for the done beat. Every expected output is derived
// from that slot with plain arithmetic.
module tb_fhe_controller;

  localparam int DIMENSION  = 3;
  localparam int DIM_WIDTH  = 2;
  localparam int ADDR_WIDTH = 10;
  localparam int ADDR_MOD   = 1 << ADDR_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [1:0]            opcode = 2'd0;
  logic                  config_en = 1'b0;
  logic [ADDR_WIDTH-1:0] op1_base_addr = '0;
  logic [ADDR_WIDTH-1:0] op2_base_addr = '0;
  logic [ADDR_WIDTH-1:0] out_base_addr = '0;
  logic [1:0]            opcode_out;
  logic [ADDR_WIDTH-1:0] op1_addr;
  logic [ADDR_WIDTH-1:0] op2_addr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  op_select;
  logic                  en;
  logic                  done;
  logic [DIM_WIDTH:0]    row;

  fhe_controller #(
    .DIMENSION (DIMENSION),
    .DIM_WIDTH (DIM_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .config_en    (config_en),
    .op1_base_addr(op1_base_addr),
    .op2_base_addr(op2_base_addr),
    .out_base_addr(out_base_addr),
    .opcode_out   (opcode_out),
    .op1_addr     (op1_addr),
    .op2_addr     (op2_addr),
    .out_addr     (out_addr),
    .op_select    (op_select),
    .en           (en),
    .done         (done),
    .row          (row)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_slot = -1;
  int m_opc  = 0;
  int m_b1   = 0;
  int m_b2   = 0;
  int m_bo   = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_slot = -1;
    m_opc  = 0;
    m_b1   = 0;
    m_b2   = 0;
    m_bo   = 0;
  endtask

  task automatic check_outputs(input string ctx);
    int r;
    r = (m_slot >= 0 && m_slot <= DIMENSION) ? m_slot : 0;
    chk_val({ctx, " row"},        32'(row),        32'(r));
    chk_val({ctx, " op1_addr"},   32'(op1_addr),   32'((m_b1 + r) % ADDR_MOD));
    chk_val({ctx, " op2_addr"},   32'(op2_addr),   32'((m_b2 + r) % ADDR_MOD));
    chk_val({ctx, " out_addr"},   32'(out_addr),   32'((m_bo + r) % ADDR_MOD));
    chk_val({ctx, " op_select"},  32'(op_select),  32'(m_slot == DIMENSION));
    chk_val({ctx, " en"},         32'(en),         32'(m_slot >= 0 && m_slot <= DIMENSION));
    chk_val({ctx, " done"},       32'(done),       32'(m_slot == DIMENSION + 1));
    chk_val({ctx, " opcode_out"}, 32'(opcode_out), 32'(m_opc));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check.
  task automatic step(input string ctx);
    @(posedge clk);
    if (rst_n) begin
      model_reset();
    end else if (m_slot == -1) begin
      if (config_en) begin
        m_slot = 0;
        m_opc  = int'(opcode);
        m_b1   = int'(op1_base_addr);
        m_b2   = int'(op2_base_addr);
        m_bo   = int'(out_base_addr);
      end
    end else if (m_slot == DIMENSION + 1) begin
      m_slot = -1;
    end else begin
      m_slot = m_slot + 1;
    end
    #1;
    check_outputs(ctx);
  endtask

  task automatic set_desc(input int opc, input int b1, input int b2, input int bo);
    opcode        = 2'(opc);
    op1_base_addr = ADDR_WIDTH'(b1);
    op2_base_addr = ADDR_WIDTH'(b2);
    out_base_addr = ADDR_WIDTH'(bo);
  endtask

  initial begin
    // Reset is held for two cycles, with config_en raised to show it is ignored.
    rst_n     = 1'b1;
    config_en = 1'b1;
    set_desc(3, 5, 6, 7);
    model_reset();
    #1;
    check_outputs("reset_async");
    step("reset");
    step("reset");
    config_en = 1'b0;
    rst_n     = 1'b0;
    step("idle");

    // ADD run with bases 10/15/20. A busy-time config pulse must be ignored.
    set_desc(2, 10, 15, 20);
    config_en = 1'b1;
    step("add");
    config_en = 1'b0;
    step("add");
    set_desc(3, 100, 200, 300);
    config_en = 1'b1;
    step("add_busy");
    config_en = 1'b0;
    for (int i = 0; i < 4; i++) step("add_tail");
    chk_val("add_opcode_held", 32'(opcode_out), 32'd2);

    // Address wrap: op1 base 1022 walks 1022, 1023, 0, 1.
    set_desc(1, 1022, 1023, 512);
    config_en = 1'b1;
    step("wrap");
    config_en = 1'b0;
    for (int i = 0; i < 6; i++) step("wrap");

    // Reset mid-run at row 2 aborts with no done pulse.
    set_desc(2, 40, 50, 60);
    config_en = 1'b1;
    step("abort");
    config_en = 1'b0;
    step("abort");
    step("abort");
    chk_val("abort_at_row2", 32'(row), 32'd2);
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    check_outputs("abort_async");
    step("abort_hold");
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) step("abort_idle");
    set_desc(0, 7, 8, 9);
    config_en = 1'b1;
    step("relaunch");
    config_en = 1'b0;
    for (int i = 0; i < 6; i++) step("relaunch");

    // Back-to-back: config_en held high re-launches after each idle beat.
    set_desc(0, 0, 0, 0);
    config_en = 1'b1;
    for (int i = 0; i < 18; i++) step("b2b");
    config_en = 1'b0;
    for (int i = 0; i < 6; i++) step("b2b_drain");

    // Randomised traffic, including occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      config_en = ($urandom_range(0, 3) == 0);
      set_desc(int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1018, 1023)) : int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 1023)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1018, 1023)) : int'($urandom_range(0, 1023)));
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b1;
        model_reset();
        #1;
        check_outputs("rand_async_rst");
        step("rand_rst");
        rst_n = 1'b0;
      end else begin
        step("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fhe_controller.md
# fhe_controller

Sequencing controller for the encrypted-arithmetic datapath. It accepts one operation descriptor: an opcode plus three base addresses. It then steps through every row of an LWE ciphertext (DIMENSION vector elements followed by the scalar b term). On each cycle it emits the operand and result addresses, an enable, the row index and an operand-path select, and pulses `done` at the end. It sits between the host configuration interface and the compute unit/scratch memory.

## Interface
Parameters:
- `PLAINTEXT_MODULUS`, default 64: system constant; no effect on sequencing.
- `PLAINTEXT_WIDTH`, default 6: system constant; no effect on sequencing.
- `CIPHERTEXT_MODULUS`, default 1024: system constant; no effect on sequencing.
- `CIPHERTEXT_WIDTH`, default 21: system constant; no effect on sequencing.
- `DIMENSION`, default 3: number of LWE vector elements. Rows 0..DIMENSION-1 are `a[i]`; row DIMENSION is `b`.
- `DIM_WIDTH`, default 2: width needed for DIMENSION-1. `row` is DIM_WIDTH+1 bits.
- `BIG_N`, default 30: system constant; no effect on sequencing.
- `PARALLEL`, default 1: rows per beat; only 1 is supported.
- `ADDR_WIDTH`, default 10: address width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-high reset. Asserted when 1, despite the name.
- `opcode`, in, 2: operation (0 ENC, 1 DEC, 2 ADD, 3 MUL).
- `config_en`, in, 1: load descriptor.
- `op1_base_addr`, in, ADDR_WIDTH: operand-1 base.
- `op2_base_addr`, in, ADDR_WIDTH: operand-2 base.
- `out_base_addr`, in, ADDR_WIDTH: result base.
- `opcode_out`, out, 2: latched opcode.
- `op1_addr`, out, ADDR_WIDTH: current operand-1 address.
- `op2_addr`, out, ADDR_WIDTH: current operand-2 address.
- `out_addr`, out, ADDR_WIDTH: current result address.
- `op_select`, out, 1: 0 selects the `a`-vector path; 1 selects the `b`-term path.
- `en`, out, 1: datapath enable for the current row.
- `done`, out, 1: one-cycle completion pulse.
- `row`, out, DIM_WIDTH+1: current row index.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `en`=0, `done`=0, `row`=0, `op_select`=0.
  - If `config_en`=1 at a clock edge: latch `opcode` into `opcode_out` and latch the three base addresses, set `row`=0, go to RUN.
- RUN:
  - `en`=1.
  - `op1_addr`/`op2_addr`/`out_addr` = latched base + `row`, computed modulo 2^ADDR_WIDTH (wrap, no saturation).
  - `op_select` = 1 iff `row`==DIMENSION.
  - Each edge: if `row`<DIMENSION, `row` increments; else go to DONE.
- DONE:
  - `done`=1, `en`=0, `op_select`=0.
  - `row` resets to 0; the next edge goes to IDLE.
- All outputs are registered. Addresses may be formed combinationally from registered base and row, but must be glitch-free relative to `clk`.
- `opcode_out` and the latched bases hold their values until the next accepted `config_en`. In IDLE and DONE the address outputs show base+0.
- `config_en` in RUN or DONE is ignored; the descriptor is not disturbed.
- Opcode does not alter the row sequence. Every opcode runs DIMENSION+1 beats; the downstream unit decodes `opcode_out`.

## Timing
- Reset (asynchronous, `rst_n`=1):
  - State IDLE.
  - `opcode_out`, `op1_addr`, `op2_addr`, `out_addr`, `op_select`, `en`, `done`, `row` all 0.
- Reset mid-RUN aborts immediately. No `done` pulse is produced.
- Latency:
  - Edge N samples `config_en`.
  - After edge N: `en`=1, `row`=0.
  - After edge N+DIMENSION: `row`=DIMENSION.
  - After edge N+DIMENSION+1: `done`=1.
  - After edge N+DIMENSION+2: IDLE.
- Total occupancy is DIMENSION+2 cycles. A new `config_en` is accepted from the first IDLE cycle after the DONE cycle.
- `config_en` held high continuously: the controller re-launches each time it returns to IDLE, sampling the current inputs.

## Test plan
- Reset: hold `rst_n`=1 for 2 cycles -> all outputs 0; raise `config_en` during reset -> ignored.
- ADD run: `opcode`=2, bases 10/15/20, `config_en` pulsed one cycle ->
  - next cycles (`row`, op1/op2/out addresses, `op_select`, `en`): (0, 10/15/20, 0, 1), (1, 11/16/21, 0, 1), (2, 12/17/22, 0, 1), (3, 13/18/23, 1, 1);
  - then `done`=1 with `en`=0;
  - then IDLE with `en`=0, `done`=0, `opcode_out`=2 held.
- Ignore during busy: while in RUN, pulse `config_en` with `opcode`=3, bases 100/200/300 -> sequence unchanged, `opcode_out` remains 2.
- Address wrap: `op1_base_addr`=1022 -> `op1_addr` 1022, 1023, 0, 1.
- Reset mid-run: assert `rst_n` at `row`=2 -> outputs 0 asynchronously, no `done` pulse; a new `config_en` after release starts at `row`=0.
- Back-to-back: `config_en` held high, `opcode`=0, bases 0/0/0 -> `en` high for 4 cycles, `done` for 1, IDLE for 1, then repeats.
